// File: rtl/vram_reader_pkg.sv
// -----------------------------------------------------------------------------
// vram_reader_pkg
// Shared definitions for the CPU-side video-memory reader: register offsets
// within the four-byte I/O window, FSM state encoding and status bit positions.
// -----------------------------------------------------------------------------
package vram_reader_pkg;

  // Register offsets relative to the block's I/O base address.
  typedef enum logic [1:0] {
    REG_ADDR = 2'd0,  // pointer shift-in
    REG_BANK = 2'd1,  // bank select (bit 0)
    REG_DATA = 2'd2,  // prefetched byte, read advances the pointer
    REG_STAT = 2'd3   // status
  } reg_off_e;

  localparam int unsigned NUM_REGS = 4;

  // Prefetch sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Status register bit positions.
  localparam int unsigned STAT_BUSY_BIT = 0;  // 1 while the prefetched byte is not valid
  localparam int unsigned STAT_BANK_BIT = 1;  // current bank

endpackage

// File: rtl/vram_reader.sv
// -----------------------------------------------------------------------------
// vram_reader
// CPU I/O window onto video memory. The CPU loads a 17-bit pointer ({bank,
// rd_addr}) through two registers; every pointer change starts a prefetch over
// the shared video-memory read port. Reading DATA while the prefetched byte is
// valid returns it, advances the pointer and prefetches the next byte.
//
// Ports
//   clock        system clock (CPU domain)
//   reset_n      asynchronous active-low reset
//   address      CPU data-space address
//   din          CPU write data
//   we           CPU write strobe (one cycle)
//   read         CPU read strobe (one cycle, coincident with the read)
//   dout         read-back data, combinational from address
//   hit          address falls inside BASE..BASE+3
//   mem_req      request for the shared video-memory read port
//   mem_gnt      grant from the port arbiter, sampled with mem_req
//   mem_address  {bank, rd_addr} presented while mem_req is high
//   mem_q        video-memory data, valid the cycle after the grant
// -----------------------------------------------------------------------------
module vram_reader
  import vram_reader_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h0028
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [7:0]  din,
  input  logic        we,
  input  logic        read,
  output logic [7:0]  dout,
  output logic        hit,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [16:0] mem_address,
  input  logic [7:0]  mem_q
);

  logic [15:0] offset;
  reg_off_e    sel;
  logic        wr_addr;
  logic        wr_bank;
  logic        rd_data;
  logic        restart;
  logic        capture;

  state_e      state;
  state_e      state_nxt;

  logic [15:0] rd_addr;
  logic        bank;
  logic [7:0]  data_reg;
  logic        valid;

  // ---------------------------------------------------------------------------
  // Address decode. Unsigned wrap-around subtraction makes a single compare
  // cover the window for any BASE, aligned or not.
  // ---------------------------------------------------------------------------
  assign offset = address - BASE;
  assign hit    = offset < 16'(NUM_REGS);
  assign sel    = reg_off_e'(offset[1:0]);

  assign wr_addr = we & hit & (sel == REG_ADDR);
  assign wr_bank = we & hit & (sel == REG_BANK);

  // A read that coincides with any write is ignored: the write alone acts.
  // A read while the byte is not yet valid returns stale data and has no
  // side effect.
  assign rd_data = read & ~we & hit & (sel == REG_DATA) & valid;

  // Any pointer change launches a fresh prefetch from whatever state we are in.
  assign restart = wr_addr | wr_bank | rd_data;

  // A restart in WAIT discards the byte arriving for the superseded pointer.
  assign capture = (state == WAIT) & ~restart;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    if (restart) begin
      state_nxt = REQ;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        REQ:     if (mem_gnt) state_nxt = WAIT;
        WAIT:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req = 1'b0;
    if (state == REQ) mem_req = 1'b1;
  end

  assign mem_address = {bank, rd_addr};

  // ---------------------------------------------------------------------------
  // Pointer, bank and prefetch data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr  <= 16'h0000;
      bank     <= 1'b0;
      data_reg <= 8'h00;
      valid    <= 1'b0;
    end else begin
      if (wr_addr)      rd_addr <= {rd_addr[7:0], din};
      else if (rd_data) rd_addr <= rd_addr + 16'd1;

      if (wr_bank) bank <= din[0];

      if (restart) begin
        valid <= 1'b0;
      end else if (capture) begin
        data_reg <= mem_q;
        valid    <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-back mux
  // ---------------------------------------------------------------------------
  always_comb begin
    dout = 8'h00;
    if (hit) begin
      case (sel)
        REG_DATA: dout = data_reg;
        REG_STAT: begin
          dout[STAT_BANK_BIT] = bank;
          dout[STAT_BUSY_BIT] = ~valid;
        end
        default:  dout = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_reader.sv
// -----------------------------------------------------------------------------
// tb_vram_reader
// Self-checking bench for vram_reader. A video-memory responder grants the
// port according to gnt_mode and returns mem[] one cycle after each grant.
// The reference model tracks only the CPU-visible pointer and bank and looks
// expected bytes up in mem[].
// -----------------------------------------------------------------------------
module tb_vram_reader;

  localparam logic [15:0] BASE   = 16'h0028;
  localparam logic [15:0] A_ADDR = BASE;
  localparam logic [15:0] A_BANK = BASE + 16'd1;
  localparam logic [15:0] A_DATA = BASE + 16'd2;
  localparam logic [15:0] A_STAT = BASE + 16'd3;

  logic        clock;
  logic        reset_n;
  logic [15:0] address;
  logic [7:0]  din;
  logic        we;
  logic        read;
  logic [7:0]  dout;
  logic        hit;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [16:0] mem_address;
  logic [7:0]  mem_q = 8'h00;

  logic [7:0]  mem [0:131071];

  int          gnt_mode;  // 0: always grant, 1: never grant, 2: random
  bit          pend = 1'b0;
  logic [16:0] pend_addr = '0;

  int          checks = 0;
  int          errors = 0;

  // Reference model of the CPU-visible pointer.
  logic [15:0] m_ptr;
  logic        m_bank;

  vram_reader #(.BASE(BASE)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .address     (address),
    .din         (din),
    .we          (we),
    .read        (read),
    .dout        (dout),
    .hit         (hit),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_address (mem_address),
    .mem_q       (mem_q)
  );

  initial begin
    clock = 1'b0;
    forever #20 clock = ~clock;
  end

  // Video-memory port: data for a grant taken at posedge N is on mem_q
  // before posedge N+1; otherwise mem_q carries junk.
  always @(negedge clock) begin
    if (pend) mem_q = mem[pend_addr];
    else      mem_q = 8'($urandom);
    case (gnt_mode)
      0:       mem_gnt = 1'b1;
      1:       mem_gnt = 1'b0;
      default: mem_gnt = 1'($urandom_range(0, 1));
    endcase
    pend      = mem_req && mem_gnt;
    pend_addr = mem_address;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Bus tasks
  // ---------------------------------------------------------------------------
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    address = a; din = d; we = 1'b1; read = 1'b0;
    @(negedge clock);
    we = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    address = a; read = 1'b1; we = 1'b0;
    #1 d = dout;
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [7:0] d);
    address = a;
    #1 d = dout;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      address = A_STAT;
      #1;
      if (dout[0] == 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: valid not seen within 200 cycles", name);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] d;
    bit req_seen;
    repeat (2) @(negedge clock);
    // valid is clear in reset, so the not-valid flag reads 1
    peek(A_STAT, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL reset_stat: got %h want 01", d); end
    peek(A_DATA, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", d); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_address !== 17'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 00000", mem_address); end
    reset_n  = 1'b1;
    gnt_mode = 0;
    req_seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      #1 if (mem_req !== 1'b0) req_seen = 1'b1;
    end
    checks++; if (req_seen) begin errors++; $display("FAIL reset_no_prefetch: mem_req rose with no register write"); end
    @(negedge clock);
    peek(BASE - 16'd1, d);
    checks++; if (hit !== 1'b0 || d !== 8'h00) begin errors++; $display("FAIL decode_below: hit %b dout %h want 0 00", hit, d); end
    peek(BASE + 16'd4, d);
    checks++; if (hit !== 1'b0 || d !== 8'h00) begin errors++; $display("FAIL decode_above: hit %b dout %h want 0 00", hit, d); end
    peek(A_ADDR, d);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL decode_base: hit %b want 1", hit); end
  endtask

  // Two back-to-back pointer writes: the second lands while the first
  // prefetch is in WAIT, so that byte must be discarded.
  task automatic test_first_fetch();
    logic [7:0] d;
    mem[17'h01234] = 8'hA5;
    mem[17'h01235] = 8'h5A;
    mem[17'h01236] = 8'hC3;
    gnt_mode = 0;
    cpu_write(A_ADDR, 8'h12);
    cpu_write(A_ADDR, 8'h34);
    peek(A_STAT, d);
    checks++; if (mem_req !== 1'b1 || mem_address !== 17'h01234 || d !== 8'h01)
      begin errors++; $display("FAIL fetch_req: mem_req %b addr %h stat %h want 1 01234 01", mem_req, mem_address, d); end
    @(negedge clock);
    peek(A_STAT, d);
    checks++; if (mem_req !== 1'b0 || d !== 8'h01)
      begin errors++; $display("FAIL fetch_wait: mem_req %b stat %h want 0 01", mem_req, d); end
    @(negedge clock);
    peek(A_STAT, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL fetch_stat: got %h want 00", d); end
    peek(A_DATA, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL fetch_data: got %h want a5", d); end
  endtask

  task automatic test_sequential_reads();
    logic [7:0] d;
    logic [7:0] exp [3];
    exp[0] = 8'hA5; exp[1] = 8'h5A; exp[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_valid("seq_wait");
      cpu_read(A_DATA, d);
      checks++; if (d !== exp[i]) begin errors++; $display("FAIL seq_read%0d: got %h want %h", i, d, exp[i]); end
    end
    peek(A_STAT, d);
    checks++; if (mem_address !== 17'h01237 || d !== 8'h01)
      begin errors++; $display("FAIL seq_advance: addr %h stat %h want 01237 01", mem_address, d); end
    wait_valid("seq_final");
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    gnt_mode = 0;
    cpu_write(A_BANK, 8'h03);
    cpu_write(A_ADDR, 8'hFF);
    cpu_write(A_ADDR, 8'hFF);
    wait_valid("wrap_wait");
    peek(A_STAT, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL wrap_stat: got %h want 02", d); end
    cpu_read(A_DATA, d);
    checks++; if (d !== mem[17'h1FFFF]) begin errors++; $display("FAIL wrap_data: got %h want %h", d, mem[17'h1FFFF]); end
    #1;
    checks++; if (mem_address !== 17'h10000) begin errors++; $display("FAIL wrap_addr: got %h want 10000", mem_address); end
    wait_valid("wrap_next");
    peek(A_DATA, d);
    checks++; if (d !== mem[17'h10000]) begin errors++; $display("FAIL wrap_next_data: got %h want %h", d, mem[17'h10000]); end
  endtask

  task automatic test_stall();
    logic [7:0] d;
    logic [7:0] stale;
    stale    = mem[17'h10000];
    gnt_mode = 1;
    cpu_write(A_BANK, 8'h00);
    cpu_write(A_ADDR, 8'h77);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      peek(A_STAT, d);
      checks++; if (mem_req !== 1'b1 || mem_address !== 17'h00077 || d !== 8'h01)
        begin errors++; $display("FAIL stall_cycle%0d: mem_req %b addr %h stat %h want 1 00077 01", i, mem_req, mem_address, d); end
    end
    cpu_read(A_DATA, d);
    checks++; if (d !== stale) begin errors++; $display("FAIL stall_stale: got %h want %h", d, stale); end
    #1;
    checks++; if (mem_address !== 17'h00077 || mem_req !== 1'b1)
      begin errors++; $display("FAIL stall_no_incr: addr %h mem_req %b want 00077 1", mem_address, mem_req); end
    gnt_mode = 0;
    wait_valid("stall_release");
    peek(A_DATA, d);
    checks++; if (d !== mem[17'h00077]) begin errors++; $display("FAIL stall_data: got %h want %h", d, mem[17'h00077]); end
  endtask

  task automatic test_ignored_writes();
    logic [7:0] d;
    cpu_write(A_DATA, 8'($urandom));
    cpu_write(A_STAT, 8'($urandom));
    peek(A_STAT, d);
    checks++; if (d !== 8'h00 || mem_req !== 1'b0 || mem_address !== 17'h00077)
      begin errors++; $display("FAIL ignored_write: stat %h mem_req %b addr %h want 00 0 00077", d, mem_req, mem_address); end
    peek(A_DATA, d);
    checks++; if (d !== mem[17'h00077]) begin errors++; $display("FAIL ignored_data: got %h want %h", d, mem[17'h00077]); end
    // write and read in the same cycle: only the (ignored) write acts
    @(negedge clock);
    address = A_DATA; din = 8'($urandom); we = 1'b1; read = 1'b1;
    @(negedge clock);
    we = 1'b0; read = 1'b0;
    peek(A_STAT, d);
    checks++; if (d !== 8'h00 || mem_address !== 17'h00077)
      begin errors++; $display("FAIL write_beats_read: stat %h addr %h want 00 00077", d, mem_address); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    bit req_seen;
    // reset while requesting
    gnt_mode = 1;
    cpu_write(A_ADDR, 8'h99);
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_req_pre: mem_req %b want 1", mem_req); end
    reset_n = 1'b0;
    peek(A_STAT, d);
    checks++; if (mem_req !== 1'b0 || d !== 8'h01)
      begin errors++; $display("FAIL rst_in_req: mem_req %b stat %h want 0 01", mem_req, d); end
    @(negedge clock);
    reset_n  = 1'b1;
    gnt_mode = 0;
    req_seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      #1 if (mem_req !== 1'b0) req_seen = 1'b1;
    end
    checks++; if (req_seen || mem_address !== 17'h0)
      begin errors++; $display("FAIL rst_no_req: req_seen %b addr %h want 0 00000", req_seen, mem_address); end
    // reset while waiting for data: the late byte must not land
    cpu_write(A_ADDR, 8'h55);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_in_wait: mem_req %b want 0", mem_req); end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    peek(A_DATA, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_late_data: got %h want 00", d); end
    peek(A_STAT, d);
    checks++; if (d !== 8'h01 || mem_req !== 1'b0)
      begin errors++; $display("FAIL rst_late_stat: stat %h mem_req %b want 01 0", d, mem_req); end
  endtask

  task automatic test_random();
    logic [7:0]  d;
    logic [7:0]  r;
    logic [15:0] a;
    logic [16:0] idx;
    int          op;
    gnt_mode = 2;
    r = 8'($urandom); cpu_write(A_BANK, r); m_bank = r[0];
    r = 8'($urandom); cpu_write(A_ADDR, r); m_ptr = {8'h00, r};
    r = 8'($urandom); cpu_write(A_ADDR, r); m_ptr = {m_ptr[7:0], r};
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          r = 8'($urandom); cpu_write(A_ADDR, r); m_ptr = {m_ptr[7:0], r};
        end
        1: begin
          r = 8'($urandom); cpu_write(A_BANK, r); m_bank = r[0];
        end
        3: begin
          cpu_write(($urandom_range(0, 1) != 0) ? A_DATA : A_STAT, 8'($urandom));
        end
        4: begin
          a = 16'($urandom);
          if (16'(a - BASE) < 16'd4) a = BASE + 16'd4;
          @(negedge clock);
          address = a; din = 8'($urandom); we = 1'($urandom_range(0, 1)); read = 1'($urandom_range(0, 1));
          #1;
          checks++; if (hit !== 1'b0 || dout !== 8'h00)
            begin errors++; $display("FAIL rnd_outside %h: hit %b dout %h want 0 00", a, hit, dout); end
          @(negedge clock);
          we = 1'b0; read = 1'b0;
        end
        default: begin
          wait_valid("rnd_wait");
          peek(A_STAT, d);
          checks++; if (d !== {6'b0, m_bank, 1'b0})
            begin errors++; $display("FAIL rnd_stat: got %h want %h", d, {6'b0, m_bank, 1'b0}); end
          idx = {m_bank, m_ptr};
          cpu_read(A_DATA, d);
          checks++; if (d !== mem[idx])
            begin errors++; $display("FAIL rnd_data @%h: got %h want %h", idx, d, mem[idx]); end
          m_ptr = m_ptr + 16'd1;
        end
      endcase
    end
    #1;
    checks++; if (mem_address !== {m_bank, m_ptr})
      begin errors++; $display("FAIL rnd_final_addr: got %h want %h", mem_address, {m_bank, m_ptr}); end
    wait_valid("rnd_final_wait");
    peek(A_DATA, d);
    idx = {m_bank, m_ptr};
    checks++; if (d !== mem[idx])
      begin errors++; $display("FAIL rnd_final_data @%h: got %h want %h", idx, d, mem[idx]); end
  endtask

  initial begin
    reset_n  = 1'b0;
    address  = 16'h0000;
    din      = 8'h00;
    we       = 1'b0;
    read     = 1'b0;
    gnt_mode = 0;
    m_ptr    = 16'h0000;
    m_bank   = 1'b0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);

    test_reset();
    test_first_fetch();
    test_sequential_reads();
    test_wrap();
    test_stall();
    test_ignored_writes();
    test_reset_mid();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
